// File: rtl/dvfs_pkg.sv
// Shared types and the bounded-step helper for the DCO frequency control front-end.
// No timing of its own; pure types and a combinational function.
package dvfs_pkg;

  localparam int CODE_W_DEF = 8;
  localparam int DIV_W_DEF  = 3;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    IDLE   = 2'd2,
    RAMP   = 2'd3
  } dco_state_t;

  // The distance is formed one bit wider than the code, so a large gap can never
  // wrap. The step is clamped to that distance, so the result lands exactly on tgt.
  function automatic logic [CODE_W_DEF-1:0] step_toward(
    input logic [CODE_W_DEF-1:0] cur,
    input logic [CODE_W_DEF-1:0] tgt,
    input logic [CODE_W_DEF-1:0] max_step
  );
    logic [CODE_W_DEF:0] mag;
    logic                up;
    up  = (tgt >= cur);
    mag = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
    if (mag > {1'b0, max_step}) begin
      mag = {1'b0, max_step};
    end
    return up ? (cur + mag[CODE_W_DEF-1:0]) : (cur - mag[CODE_W_DEF-1:0]);
  endfunction

endpackage

// File: rtl/clk_div_pow2.sv
// Power-of-two clock divider: clk_div toggles every 2^div_sel cycles of clk, with 50% duty.
// Latency: a new div_sel takes effect at the next terminal count. No backpressure; held at 0 while en=0.
module clk_div_pow2 #(
  parameter int DIV_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_sel,
  output logic             clk_div
);

  localparam int CNT_W = 1 << DIV_W;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] half_m1;
  logic [DIV_W-1:0] sel_q;
  logic             term;

  // The ratio is taken from sel_q, which only changes at the terminal count.
  // A half period that has already started therefore always runs to full length.
  assign half_m1 = (CNT_W'(1) << sel_q) - 1'b1;
  assign term    = (cnt_q == half_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sel_q   <= '0;
      clk_div <= 1'b0;
    end else if (!en) begin
      cnt_q   <= '0;
      sel_q   <= div_sel;
      clk_div <= 1'b0;
    end else if (term) begin
      cnt_q   <= '0;
      sel_q   <= div_sel;
      clk_div <= ~clk_div;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/dco_freq_ctrl.sv
// DCO control front-end: accepts a target code, ramps dco_code toward it in bounded steps, settles, then reports lock.
// Latency: one step every STEP_INTERVAL cycles, then SETTLE_CYC cycles before lock. Backpressure: req_ready is high only when IDLE and en is high.
module dco_freq_ctrl
  import dvfs_pkg::*;
#(
  parameter int                 CODE_W        = CODE_W_DEF,
  parameter int                 DIV_W         = DIV_W_DEF,
  parameter int                 STEP_MAX      = 4,
  parameter int                 STEP_INTERVAL = 8,
  parameter int                 SETTLE_CYC    = 32,
  parameter logic [CODE_W-1:0]  RESET_CODE    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req_valid,
  input  logic [CODE_W-1:0] req_code,
  output logic              req_ready,
  input  logic [DIV_W-1:0]  div_sel,
  output logic [CODE_W-1:0] dco_code,
  output logic              dco_en,
  output logic              locked,
  output logic              done,
  output logic              clk_div
);

  localparam int CNT_MAX = (SETTLE_CYC > STEP_INTERVAL) ? SETTLE_CYC : STEP_INTERVAL;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_INTERVAL - 1);

  dco_state_t        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] tgt_q, tgt_d;
  logic [CODE_W-1:0] code_step;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              accept;

  assign code_step = CODE_W'(step_toward(CODE_W_DEF'(code_q), CODE_W_DEF'(tgt_q),
                                         CODE_W_DEF'(STEP_MAX)));

  assign req_ready = (state_q == IDLE) && en;
  assign accept    = req_valid && req_ready;

  assign dco_code  = code_q;
  assign dco_en    = (state_q != OFF);
  assign locked    = (state_q == IDLE);
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      code_q  <= RESET_CODE;
      tgt_q   <= RESET_CODE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // One down-counter serves both the settle window and the step interval.
  // Dropping en freezes code and target wherever they are; the ramp resumes after the next settle.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!en) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
        SETTLE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (code_q == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RAMP;
            cnt_d   = STEP_LOAD;
          end
        end
        IDLE: begin
          if (accept) begin
            tgt_d = req_code;
            if (req_code != code_q) begin
              state_d = RAMP;
              cnt_d   = STEP_LOAD;
            end
          end
        end
        RAMP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            code_d = code_step;
            if (code_step == tgt_q) begin
              state_d = SETTLE;
              cnt_d   = SETTLE_LOAD;
            end else begin
              cnt_d   = STEP_LOAD;
            end
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  clk_div_pow2 #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (dco_en),
    .div_sel (div_sel),
    .clk_div (clk_div)
  );

endmodule
